// File: rtl/scr1_dmem_arb.sv
// -----------------------------------------------------------------------------
// scr1_dmem_arb
//
// Shares the single core-side request/response interface of the data memory
// AHB bridge between two requesters: port 0 (core LSU) and port 1 (a secondary
// master such as a debug or DMA engine).
//
// One requester is granted per transfer and its request is forwarded to the
// bridge. The bridge pipelines several outstanding transfers, so the port that
// issued each accepted transfer is recorded in an in-order ID FIFO. Each bridge
// response is routed back to the port at the FIFO head.
//
// Both the request path and the response path are purely combinational. The
// only state is the ID FIFO, its pointers/count and the arbitration state.
//
// Parameters:
//   OUTST_DEPTH  maximum accepted-but-unanswered transfers (power of two >= 2)
//   ARB_MODE     0 = round-robin, 1 = fixed priority (port 0 wins)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s0_req / s0_req_ack             port 0 request handshake
//   s0_cmd, s0_width                port 0 command and access width
//   s0_addr, s0_wdata               port 0 byte address and write data
//   s0_rdata, s0_resp               port 0 read data and response
//   s1_*                            same set, for port 1
//   m_req / m_req_ack               bridge request handshake
//   m_cmd, m_width, m_addr, m_wdata muxed request fields to the bridge
//   m_rdata, m_resp                 bridge read data and response
// -----------------------------------------------------------------------------

package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg


module scr1_dmem_arb
    import scr1_memif_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH = 4,
    parameter bit          ARB_MODE    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,

    // Port 0 (core LSU)
    input  logic                 s0_req,
    output logic                 s0_req_ack,
    input  type_scr1_mem_cmd_e   s0_cmd,
    input  type_scr1_mem_width_e s0_width,
    input  logic [31:0]          s0_addr,
    input  logic [31:0]          s0_wdata,
    output logic [31:0]          s0_rdata,
    output type_scr1_mem_resp_e  s0_resp,

    // Port 1 (secondary master)
    input  logic                 s1_req,
    output logic                 s1_req_ack,
    input  type_scr1_mem_cmd_e   s1_cmd,
    input  type_scr1_mem_width_e s1_width,
    input  logic [31:0]          s1_addr,
    input  logic [31:0]          s1_wdata,
    output logic [31:0]          s1_rdata,
    output type_scr1_mem_resp_e  s1_resp,

    // Bridge side
    output logic                 m_req,
    input  logic                 m_req_ack,
    output type_scr1_mem_cmd_e   m_cmd,
    output type_scr1_mem_width_e m_width,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_wdata,
    input  logic [31:0]          m_rdata,
    input  type_scr1_mem_resp_e  m_resp
);

    localparam int unsigned PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUTST_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTST_DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [OUTST_DEPTH-1:0] id_fifo;     // one bit per slot: issuing port
    logic                   lock;        // a presented request is waiting for ack
    logic                   lock_id;     // port that owns the pending request
    logic                   rr_last;     // port of the most recent accept

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic grant;
    logic grant_req;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic resp_evt;
    logic pop;
    logic head;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // A pending (unacknowledged) request keeps the grant so the fields seen
    // by the bridge stay stable until it accepts them.
    always_comb begin
        grant = 1'b0;
        if (lock) begin
            grant = lock_id;
        end else if (s0_req && !s1_req) begin
            grant = 1'b0;
        end else if (s1_req && !s0_req) begin
            grant = 1'b1;
        end else if (s0_req && s1_req) begin
            grant = ARB_MODE ? 1'b0 : ~rr_last;
        end
    end

    assign grant_req = grant ? s1_req : s0_req;

    // Gating with the full flag means a push is never attempted when full.
    assign m_req   = grant_req & ~fifo_full & ~rst;
    assign m_cmd   = grant ? s1_cmd   : s0_cmd;
    assign m_width = grant ? s1_width : s0_width;
    assign m_addr  = grant ? s1_addr  : s0_addr;
    assign m_wdata = grant ? s1_wdata : s0_wdata;

    assign accept     = m_req & m_req_ack;
    assign s0_req_ack = accept & ~grant;
    assign s1_req_ack = accept &  grant;

    // A response with nothing outstanding is dropped and leaves the pointers
    // untouched.
    assign resp_evt = (m_resp != SCR1_MEM_RESP_NOTRDY);
    assign pop      = resp_evt & ~fifo_empty & ~rst;
    assign head     = id_fifo[rd_ptr];

    assign s0_resp  = (pop && !head) ? m_resp : SCR1_MEM_RESP_NOTRDY;
    assign s1_resp  = (pop &&  head) ? m_resp : SCR1_MEM_RESP_NOTRDY;
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;

    // -------------------------------------------------------------------------
    // Arbitration state and FIFO pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
            rr_last <= 1'b1;          // port 0 is favoured first after reset
        end else begin
            if (accept) begin
                wr_ptr  <= wr_ptr + 1'b1;   // power-of-two depth: natural wrap
                rr_last <= grant;
                lock    <= 1'b0;
            end else if (m_req) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // Simultaneous push and pop leaves the count unchanged.
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // ID FIFO storage (no reset needed: slots are only read after a push)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            id_fifo[wr_ptr] <= grant;
        end
    end

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
    a_resp_when_empty : assert property (
        @(posedge clk) disable iff (rst) !(resp_evt && fifo_empty)
    );

    a_req_held : assert property (
        @(posedge clk) disable iff (rst)
        (m_req && !m_req_ack) |=> (m_req && $stable(m_addr) && $stable(m_cmd)
                                   && $stable(m_width) && $stable(m_wdata))
    );

endmodule : scr1_dmem_arb

// File: tb/tb_scr1_dmem_arb.sv
module tb_scr1_dmem_arb;
    import scr1_memif_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam bit          ARB   = 1'b0;

    logic                 clk;
    logic                 rst;
    logic                 s0_req, s0_req_ack, s1_req, s1_req_ack;
    type_scr1_mem_cmd_e   s0_cmd, s1_cmd, m_cmd;
    type_scr1_mem_width_e s0_width, s1_width, m_width;
    logic [31:0]          s0_addr, s0_wdata, s0_rdata, s1_addr, s1_wdata, s1_rdata;
    type_scr1_mem_resp_e  s0_resp, s1_resp, m_resp;
    logic                 m_req, m_req_ack;
    logic [31:0]          m_addr, m_wdata, m_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scr1_dmem_arb #(.OUTST_DEPTH(DEPTH), .ARB_MODE(ARB)) dut (
        .clk(clk), .rst(rst),
        .s0_req(s0_req), .s0_req_ack(s0_req_ack), .s0_cmd(s0_cmd), .s0_width(s0_width),
        .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_rdata(s0_rdata), .s0_resp(s0_resp),
        .s1_req(s1_req), .s1_req_ack(s1_req_ack), .s1_cmd(s1_cmd), .s1_width(s1_width),
        .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_rdata(s1_rdata), .s1_resp(s1_resp),
        .m_req(m_req), .m_req_ack(m_req_ack), .m_cmd(m_cmd), .m_width(m_width),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- requesters ----------------
    logic                 act     [2];
    type_scr1_mem_cmd_e   p_cmd   [2];
    type_scr1_mem_width_e p_width [2];
    logic [31:0]          p_addr  [2];
    logic [31:0]          p_wdata [2];

    assign s0_req   = act[0];
    assign s0_cmd   = p_cmd[0];
    assign s0_width = p_width[0];
    assign s0_addr  = p_addr[0];
    assign s0_wdata = p_wdata[0];
    assign s1_req   = act[1];
    assign s1_cmd   = p_cmd[1];
    assign s1_width = p_width[1];
    assign s1_addr  = p_addr[1];
    assign s1_wdata = p_wdata[1];

    // stimulus knobs
    int pct [2];
    int ack_pct, err_pct, lat_min, lat_max;
    bit resp_en;
    bit force_new [2];
    bit ack_pat [$];

    // ---------------- reference model ----------------
    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        int          ready;
    } br_t;

    exp_t exp_q [$];         // expected responses, in issue order
    br_t  bq    [$];         // bridge's own view of outstanding transfers
    int   out_cnt  = 0;
    bit   rr_last  = 1'b1;
    bit   locked   = 1'b0;
    bit   lock_port = 1'b0;

    bit          acc_evt = 1'b0, rsp_taken = 1'b0, was_rst = 1'b0;
    bit          acc_port;
    logic [31:0] acc_addr;
    int          acc_cyc;
    int          cyc = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEADBEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic timeout(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Request side: predict the winner from the arbitration rules and check
    // handshake, muxed fields and outstanding count.
    always @(negedge clk) begin : model
        bit win, exp_mreq, accept, pop;
        acc_evt   = 1'b0;
        rsp_taken = 1'b0;
        was_rst   = rst;
        if (rst) begin
            chk("rst_m_req", 32'(m_req), 32'd0);
            chk("rst_req_ack", 32'({s0_req_ack, s1_req_ack}), 32'd0);
            out_cnt = 0;
            rr_last = 1'b1;
            locked  = 1'b0;
        end else begin
            if (locked)                 win = lock_port;
            else if (act[0] && !act[1]) win = 1'b0;
            else if (act[1] && !act[0]) win = 1'b1;
            else if (act[0] && act[1])  win = ARB ? 1'b0 : ~rr_last;
            else                        win = 1'b0;
            exp_mreq = act[win] && (out_cnt < DEPTH);

            chk("count", 32'(dut.count), 32'(out_cnt));
            chk("m_req", 32'(m_req), 32'(exp_mreq));
            chk("s0_req_ack", 32'(s0_req_ack), 32'(exp_mreq && m_req_ack && !win));
            chk("s1_req_ack", 32'(s1_req_ack), 32'(exp_mreq && m_req_ack && win));
            if (exp_mreq) begin
                chk("m_addr",  m_addr,  p_addr[win]);
                chk("m_wdata", m_wdata, p_wdata[win]);
                chk("m_cmd_width", 32'({m_cmd, m_width}), 32'({p_cmd[win], p_width[win]}));
            end

            accept = exp_mreq && m_req_ack;
            pop    = (m_resp != SCR1_MEM_RESP_NOTRDY) && (out_cnt > 0);
            if (accept) begin
                exp_t e;
                e.port  = win;
                e.rdata = mem_f(p_addr[win]);
                exp_q.push_back(e);
                rr_last  = win;
                locked   = 1'b0;
                acc_evt  = 1'b1;
                acc_port = win;
                acc_addr = m_addr;
                acc_cyc  = cyc;
            end else if (exp_mreq) begin
                locked    = 1'b1;
                lock_port = win;
            end
            out_cnt   = out_cnt + int'(accept) - int'(pop);
            rsp_taken = (m_resp != SCR1_MEM_RESP_NOTRDY);
        end
    end

    // Response side: whenever the DUT (or the bridge) presents a response,
    // pop the expected issuer and check routing.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            exp_q.delete();
            chk("rst_s0_resp", 32'(s0_resp), 32'(SCR1_MEM_RESP_NOTRDY));
            chk("rst_s1_resp", 32'(s1_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        end else if (m_resp != SCR1_MEM_RESP_NOTRDY || s0_resp != SCR1_MEM_RESP_NOTRDY ||
                     s1_resp != SCR1_MEM_RESP_NOTRDY) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got s0=%0d s1=%0d required none (t=%0t)",
                         s0_resp, s1_resp, $time);
            end else begin
                e = exp_q.pop_front();
                if (!e.port) begin
                    chk("s0_resp", 32'(s0_resp), 32'(m_resp));
                    chk("s1_resp_idle", 32'(s1_resp), 32'(SCR1_MEM_RESP_NOTRDY));
                    if (m_resp == SCR1_MEM_RESP_RDY_OK) chk("s0_rdata", s0_rdata, e.rdata);
                end else begin
                    chk("s1_resp", 32'(s1_resp), 32'(m_resp));
                    chk("s0_resp_idle", 32'(s0_resp), 32'(SCR1_MEM_RESP_NOTRDY));
                    if (m_resp == SCR1_MEM_RESP_RDY_OK) chk("s1_rdata", s1_rdata, e.rdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic new_txn(input int p);
        logic [31:0] r;
        r          = $urandom();
        act[p]     = 1'b1;
        p_cmd[p]   = type_scr1_mem_cmd_e'(r[0]);
        p_width[p] = type_scr1_mem_width_e'(2'($urandom_range(2)));
        p_addr[p]  = {(p == 1), r[30:2], 2'b00};
        p_wdata[p] = $urandom();
    endtask

    task automatic step();
        br_t b;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            bq.delete();
        end else begin
            if (rsp_taken && bq.size() > 0) void'(bq.pop_front());
            if (acc_evt) begin
                b.addr  = acc_addr;
                b.ready = acc_cyc + int'($urandom_range(lat_max, lat_min));
                bq.push_back(b);
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (acc_evt && acc_port == 1'(p)) act[p] = 1'b0;
            if (!act[p] && (force_new[p] || int'($urandom_range(99)) < pct[p])) new_txn(p);
            force_new[p] = 1'b0;
        end
        if (ack_pat.size() > 0) m_req_ack = ack_pat.pop_front();
        else                    m_req_ack = (int'($urandom_range(99)) < ack_pct);
        if (!rst && resp_en && bq.size() > 0 && bq[0].ready <= cyc) begin
            m_resp  = (int'($urandom_range(99)) < err_pct) ? SCR1_MEM_RESP_RDY_ER
                                                           : SCR1_MEM_RESP_RDY_OK;
            m_rdata = mem_f(bq[0].addr);
        end else begin
            m_resp  = SCR1_MEM_RESP_NOTRDY;
            m_rdata = $urandom();
        end
    endtask

    task automatic wait_cnt(input int n, input string nm);
        for (int i = 0; i < 100; i++) begin
            if (out_cnt == n) return;
            step();
        end
        timeout(nm);
    endtask

    task automatic drain();
        pct[0] = 0; pct[1] = 0; ack_pct = 100; resp_en = 1'b1;
        lat_min = 1; lat_max = 1; err_pct = 0;
        for (int i = 0; i < 200; i++) begin
            if (!act[0] && !act[1] && out_cnt == 0 && bq.size() == 0) return;
            step();
        end
        timeout("drain");
    endtask

    initial begin
        rst = 1'b1;
        act[0] = 1'b0; act[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_cmd[p] = SCR1_MEM_CMD_RD; p_width[p] = SCR1_MEM_WIDTH_WORD;
            p_addr[p] = '0; p_wdata[p] = '0; pct[p] = 0; force_new[p] = 1'b0;
        end
        m_req_ack = 1'b0; m_resp = SCR1_MEM_RESP_NOTRDY; m_rdata = '0;
        ack_pct = 100; err_pct = 0; lat_min = 2; lat_max = 2; resp_en = 1'b1;

        // Port 0 read of 0x100 is pending through reset; bridge noise must be gated.
        act[0] = 1'b1; p_addr[0] = 32'h0000_0100;
        repeat (3) begin
            step();
            m_resp  = SCR1_MEM_RESP_RDY_OK;
            m_rdata = 32'h1234_5678;
        end
        step();
        rst = 1'b0;
        repeat (6) step();

        // Both ports requesting continuously with an always-acking bridge.
        pct[0] = 100; pct[1] = 100; ack_pct = 100; lat_min = 1; lat_max = 3;
        repeat (40) step();
        drain();

        // Stall lock: make port 1 the round-robin favourite, then stall it 3 cycles.
        force_new[0] = 1'b1; ack_pat.push_back(1'b1);
        step();
        force_new[0] = 1'b1; force_new[1] = 1'b1;
        ack_pat.push_back(1'b0); ack_pat.push_back(1'b0); ack_pat.push_back(1'b0);
        ack_pat.push_back(1'b1); ack_pat.push_back(1'b1);
        repeat (6) step();
        drain();

        // Full FIFO, then release and run well past pointer wrap-around.
        pct[0] = 100; pct[1] = 100; ack_pct = 100; resp_en = 1'b0;
        wait_cnt(DEPTH, "fill_fifo");
        repeat (3) step();
        resp_en = 1'b1; lat_min = 1; lat_max = 2;
        repeat (30) step();
        drain();

        // Push and pop in the same cycle at count 2, popping with RDY_ER.
        resp_en = 1'b0;
        force_new[0] = 1'b1; step();
        force_new[1] = 1'b1; step();
        force_new[0] = 1'b1; resp_en = 1'b1; err_pct = 100; step();
        err_pct = 0;
        repeat (6) step();
        drain();

        // Reset with 3 transfers outstanding.
        pct[0] = 100; pct[1] = 100; ack_pct = 100; resp_en = 1'b0;
        wait_cnt(3, "fill_three");
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        resp_en = 1'b1;
        drain();

        // Randomised traffic.
        pct[0] = 60; pct[1] = 60; ack_pct = 70; err_pct = 15;
        lat_min = 1; lat_max = 4; resp_en = 1'b1;
        repeat (600) step();
        drain();
        step();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_scr1_dmem_arb
